ps2_zx_keyboard: RTL and testbench

- PS/2 keyboard receiver (device-to-host, scan code set 2) that keeps a ZX Spectrum 8x5 key matrix and answers CPU reads of port FE.
- The CPU drives the high address byte, A[15:8], as the row select and reads back the 5 active-low column bits.
- This is the input side of the ULA port: the CPU's OUT to FE sets the border, and its IN from FE reads this block.
- Clocked from clock_25 at the top level; the PS/2 lines arrive raw from the pins.

---
 rtl/ps2_zx_keyboard.sv | 246 ++++++++++++++++++++++++
 tb/tb_ps2_zx_keyboard.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_zx_keyboard.sv
// ps2_zx_keyboard: PS/2 set-2 receiver that maintains a ZX Spectrum 8x5 key
// matrix and answers CPU reads of port FE (row select on A[15:8]).
//
// state  | meaning
// IDLE   | line idle, waiting for a start bit (data low at a clock fall)
// DATA   | shifting in eight data bits, LSB first
// PARITY | capturing the parity bit
// STOP   | checking stop bit and odd parity, handing a good byte on
module ps2_zx_keyboard #(
    parameter int TIMEOUT_CYCLES = 25000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic [7:0] row_sel,
    output logic [4:0] kbd_data,
    output logic [7:0] scan_code,
    output logic       scan_strobe,
    output logic       parity_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

    logic          clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
    logic          clk_filt_q, clk_prev_q;
    logic [FW-1:0] flt_cnt_q;
    state_t        state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [TW-1:0] to_cnt_q;
    logic [7:0]    scan_code_q;
    logic          scan_strobe_q, parity_err_q;
    logic          ext_q, brk_q;
    logic [7:0][4:0] pressed_q;

    logic          fall_d, frame_ok_d, stop_ok_d, stop_bad_d;
    logic          key_hit_d;
    logic [2:0]    key_row_d, key_col_d;
    logic [4:0]    kbd_d;

    // Two-stage synchronizers on both raw PS/2 lines; idle level is high.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2_clk;
            clk_sync_q <= clk_meta_q;
            dat_meta_q <= ps2_dat;
            dat_sync_q <= dat_meta_q;
        end
    end

    // Glitch filter: the filtered clock follows only after FILTER_LEN differing samples in a row.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_filt_q <= 1'b1;
            clk_prev_q <= 1'b1;
            flt_cnt_q  <= '0;
        end else begin
            clk_prev_q <= clk_filt_q;
            if (clk_sync_q == clk_filt_q) begin
                flt_cnt_q <= '0;
            end else if (flt_cnt_q == FLT_LAST) begin
                clk_filt_q <= clk_sync_q;
                flt_cnt_q  <= '0;
            end else begin
                flt_cnt_q <= flt_cnt_q + 1'b1;
            end
        end
    end

    assign fall_d     = clk_prev_q & ~clk_filt_q;
    assign frame_ok_d = dat_sync_q & (^{shift_q, parity_q});
    assign stop_ok_d  = (state_q == ST_STOP) & fall_d & frame_ok_d;
    assign stop_bad_d = (state_q == ST_STOP) & fall_d & ~frame_ok_d;

    // Frame receiver with inactivity timeout; the timer reloads on every clock fall.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            to_cnt_q      <= TO_LOAD;
            scan_code_q   <= '0;
            scan_strobe_q <= 1'b0;
            parity_err_q  <= 1'b0;
        end else begin
            scan_strobe_q <= 1'b0;
            parity_err_q  <= 1'b0;
            if (fall_d) begin
                to_cnt_q <= TO_LOAD;
                case (state_q)
                    ST_IDLE: begin
                        if (!dat_sync_q) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_q <= {dat_sync_q, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        parity_q <= dat_sync_q;
                        state_q  <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_q <= ST_IDLE;
                        if (frame_ok_d) begin
                            scan_code_q   <= shift_q;
                            scan_strobe_q <= 1'b1;
                        end else begin
                            parity_err_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end else if (state_q != ST_IDLE) begin
                if (to_cnt_q == '0) begin
                    state_q <= ST_IDLE;
                end else begin
                    to_cnt_q <= to_cnt_q - 1'b1;
                end
            end
        end
    end

    // Scan code to matrix position, packed as {row, column}; extended codes only know right Ctrl.
    always_comb begin
        key_hit_d = 1'b1;
        {key_row_d, key_col_d} = 6'o00;
        if (ext_q) begin
            if (shift_q == 8'h14) begin
                {key_row_d, key_col_d} = 6'o71;
            end else begin
                key_hit_d = 1'b0;
            end
        end else begin
            case (shift_q)
                8'h12, 8'h59: {key_row_d, key_col_d} = 6'o00;
                8'h1A: {key_row_d, key_col_d} = 6'o01;
                8'h22: {key_row_d, key_col_d} = 6'o02;
                8'h21: {key_row_d, key_col_d} = 6'o03;
                8'h2A: {key_row_d, key_col_d} = 6'o04;
                8'h1C: {key_row_d, key_col_d} = 6'o10;
                8'h1B: {key_row_d, key_col_d} = 6'o11;
                8'h23: {key_row_d, key_col_d} = 6'o12;
                8'h2B: {key_row_d, key_col_d} = 6'o13;
                8'h34: {key_row_d, key_col_d} = 6'o14;
                8'h15: {key_row_d, key_col_d} = 6'o20;
                8'h1D: {key_row_d, key_col_d} = 6'o21;
                8'h24: {key_row_d, key_col_d} = 6'o22;
                8'h2D: {key_row_d, key_col_d} = 6'o23;
                8'h2C: {key_row_d, key_col_d} = 6'o24;
                8'h16: {key_row_d, key_col_d} = 6'o30;
                8'h1E: {key_row_d, key_col_d} = 6'o31;
                8'h26: {key_row_d, key_col_d} = 6'o32;
                8'h25: {key_row_d, key_col_d} = 6'o33;
                8'h2E: {key_row_d, key_col_d} = 6'o34;
                8'h45: {key_row_d, key_col_d} = 6'o40;
                8'h46: {key_row_d, key_col_d} = 6'o41;
                8'h3E: {key_row_d, key_col_d} = 6'o42;
                8'h3D: {key_row_d, key_col_d} = 6'o43;
                8'h36: {key_row_d, key_col_d} = 6'o44;
                8'h4D: {key_row_d, key_col_d} = 6'o50;
                8'h44: {key_row_d, key_col_d} = 6'o51;
                8'h43: {key_row_d, key_col_d} = 6'o52;
                8'h3C: {key_row_d, key_col_d} = 6'o53;
                8'h35: {key_row_d, key_col_d} = 6'o54;
                8'h5A: {key_row_d, key_col_d} = 6'o60;
                8'h4B: {key_row_d, key_col_d} = 6'o61;
                8'h42: {key_row_d, key_col_d} = 6'o62;
                8'h3B: {key_row_d, key_col_d} = 6'o63;
                8'h33: {key_row_d, key_col_d} = 6'o64;
                8'h29: {key_row_d, key_col_d} = 6'o70;
                8'h14: {key_row_d, key_col_d} = 6'o71;
                8'h3A: {key_row_d, key_col_d} = 6'o72;
                8'h31: {key_row_d, key_col_d} = 6'o73;
                8'h32: {key_row_d, key_col_d} = 6'o74;
                default: key_hit_d = 1'b0;
            endcase
        end
    end

    // Decoder: prefix flags and matrix updates, acting in the STOP cycle of a frame.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pressed_q <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
        end else if (stop_ok_d) begin
            case (shift_q)
                8'hE0: ext_q <= 1'b1;
                8'hF0: brk_q <= 1'b1;
                8'hAA, 8'hFA: ;
                8'h00, 8'hFF: begin
                    pressed_q <= '0;
                    ext_q     <= 1'b0;
                    brk_q     <= 1'b0;
                end
                default: begin
                    if (key_hit_d) begin
                        pressed_q[key_row_d][key_col_d] <= ~brk_q;
                    end
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                end
            endcase
        end else if (stop_bad_d) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end
    end

    // Port FE read: a column reads low if any selected row has that key down.
    always_comb begin
        kbd_d = 5'h1F;
        for (int r = 0; r < 8; r++) begin
            if (!row_sel[r]) begin
                kbd_d = kbd_d & ~pressed_q[r];
            end
        end
    end

    assign kbd_data    = kbd_d;
    assign scan_code   = scan_code_q;
    assign scan_strobe = scan_strobe_q;
    assign parity_err  = parity_err_q;

endmodule

// File: tb/tb_ps2_zx_keyboard.sv
// Bench for ps2_zx_keyboard: drives PS/2 frames and compares against a key-table model.
module tb_ps2_zx_keyboard;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] row_sel = 8'hFF;
    logic [4:0] kbd_data;
    logic [7:0] scan_code;
    logic       scan_strobe;
    logic       parity_err;

    int errors = 0;
    int checks = 0;
    int n_strobe = 0;
    int n_perr = 0;
    logic [7:0] last_code = 8'h00;
    bit settled = 1'b0;
    bit rand_rows = 1'b0;

    // Model state: 40 keys in row-major order (row*5 + column), plus prefix flags.
    bit model_pressed [40];
    bit m_ext = 1'b0;
    bit m_brk = 1'b0;
    logic [7:0] keymap [40] = '{
        8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A,
        8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
        8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
        8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
        8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,
        8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
        8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,
        8'h29, 8'h14, 8'h3A, 8'h31, 8'h32
    };

    localparam int HALF = 20;

    ps2_zx_keyboard dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .row_sel    (row_sel),
        .kbd_data   (kbd_data),
        .scan_code  (scan_code),
        .scan_strobe(scan_strobe),
        .parity_err (parity_err)
    );

    always #20 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int lookup(input logic [7:0] b, input bit ext);
        if (ext) return (b == 8'h14) ? 36 : -1;
        if (b == 8'h59) return 0;
        for (int i = 0; i < 40; i++) begin
            if (keymap[i] == b) return i;
        end
        return -1;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 40; i++) model_pressed[i] = 1'b0;
        m_ext = 1'b0;
        m_brk = 1'b0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int idx;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hAA || b == 8'hFA) begin end
        else if (b == 8'h00 || b == 8'hFF) model_clear();
        else begin
            idx = lookup(b, m_ext);
            if (idx >= 0) model_pressed[idx] = !m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    function automatic logic [4:0] model_kbd(input logic [7:0] rs);
        logic [4:0] v;
        v = 5'h1F;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 5; c++)
                if (!rs[r] && model_pressed[r*5 + c]) v[c] = 1'b0;
        return v;
    endfunction

    // Event counters for the pulse outputs.
    always @(negedge clk) begin
        if (scan_strobe) begin
            n_strobe++;
            last_code = scan_code;
        end
        if (parity_err) n_perr++;
    end

    // Continuous comparison whenever the line is quiet and the model is up to date.
    always @(negedge clk) begin
        if (settled) begin
            chk("kbd_data", {27'd0, kbd_data}, {27'd0, model_kbd(row_sel)});
            chk("strobe_quiet", {31'd0, scan_strobe}, 32'd0);
            chk("perr_quiet", {31'd0, parity_err}, 32'd0);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (rand_rows) row_sel = 8'($urandom);
        end
    end

    task automatic ps2_bit(input bit b);
        ps2_dat = b;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad);
        int s0;
        int p0;
        bit par;
        s0 = n_strobe;
        p0 = n_perr;
        par = (~^b) ^ bad;
        settled = 1'b0;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(1'b1);
        ps2_dat = 1'b1;
        repeat (30) @(posedge clk);
        if (!bad) begin
            chk("strobe_count", n_strobe - s0, 1);
            chk("scan_code", {24'd0, last_code}, {24'd0, b});
            chk("perr_count", n_perr - p0, 0);
            model_byte(b);
        end else begin
            chk("bad_strobe_count", n_strobe - s0, 0);
            chk("bad_perr_count", n_perr - p0, 1);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
        settled = 1'b1;
    endtask

    task automatic lit(input string name, input logic [7:0] rs, input logic [4:0] exp);
        rand_rows = 1'b0;
        row_sel = rs;
        @(negedge clk);
        chk({name, " dut"}, {27'd0, kbd_data}, {27'd0, exp});
        chk({name, " model"}, {27'd0, model_kbd(rs)}, {27'd0, exp});
        rand_rows = 1'b1;
    endtask

    initial begin
        int s0;
        int p0;
        int r;
        logic [7:0] code;
        logic [7:0] misc [5];
        misc = '{8'h00, 8'hFF, 8'hAA, 8'hFA, 8'h59};
        model_clear();

        reset_n = 1'b0;
        repeat (5) @(posedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        settled = 1'b1;
        rand_rows = 1'b1;
        lit("reset FE", 8'hFE, 5'h1F);
        chk("reset scan_code", {24'd0, scan_code}, 32'd0);
        chk("reset strobes", n_strobe, 0);

        send_frame(8'h1C, 1'b0);
        lit("A press", 8'hFD, 5'h1E);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        lit("A release", 8'hFD, 5'h1F);

        send_frame(8'h12, 1'b0);
        send_frame(8'h1A, 1'b0);
        lit("CS+Z", 8'hFE, 5'h1C);
        send_frame(8'h29, 1'b0);
        lit("rows 0+7", 8'h7E, 5'h1C);
        lit("all rows", 8'h00, 5'h1C);
        lit("space", 8'h7F, 5'h1E);
        send_frame(8'hFF, 1'b0);
        lit("FF release", 8'h00, 5'h1F);

        send_frame(8'hE0, 1'b0);
        send_frame(8'h14, 1'b0);
        lit("rctrl", 8'h7F, 5'h1D);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h14, 1'b0);
        lit("rctrl up", 8'h7F, 5'h1F);
        send_frame(8'hE0, 1'b0);
        send_frame(8'h1C, 1'b0);
        lit("ext 1C", 8'hFD, 5'h1F);

        send_frame(8'h1C, 1'b1);
        lit("bad parity", 8'hFD, 5'h1F);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h33, 1'b1);
        send_frame(8'h1C, 1'b0);
        lit("brk cleared", 8'hFD, 5'h1E);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);

        // Abandoned frame: start bit plus four data bits, then silence past the timeout.
        settled = 1'b0;
        s0 = n_strobe;
        p0 = n_perr;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0]);
        ps2_dat = 1'b1;
        repeat (25200) @(posedge clk);
        chk("timeout strobes", n_strobe - s0, 0);
        chk("timeout perr", n_perr - p0, 0);
        send_frame(8'h5A, 1'b0);
        lit("enter", 8'hBF, 5'h1E);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h5A, 1'b0);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 99);
            if (r < 60) code = keymap[$urandom_range(0, 39)];
            else if (r < 72) code = 8'hE0;
            else if (r < 87) code = 8'hF0;
            else if (r < 92) code = misc[$urandom_range(0, 4)];
            else code = 8'($urandom);
            send_frame(code, $urandom_range(0, 9) == 0);
        end

        // Reset in the middle of a frame, with a key held down beforehand.
        send_frame(8'h1C, 1'b0);
        settled = 1'b0;
        s0 = n_strobe;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        reset_n = 1'b0;
        repeat (4) @(posedge clk);
        reset_n = 1'b1;
        ps2_dat = 1'b1;
        model_clear();
        repeat (50) @(posedge clk);
        settled = 1'b1;
        chk("mid reset strobes", n_strobe - s0, 0);
        chk("mid reset scan_code", {24'd0, scan_code}, 32'd0);
        lit("mid reset all rows", 8'h00, 5'h1F);
        send_frame(8'h2C, 1'b0);
        lit("T after reset", 8'hFB, 5'h0F);

        settled = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
